// File: rtl/cim_pkg.sv
// Shared definitions for the CIM output path: controller states and width helpers.
package cim_pkg;

    // Controller states of the shift-and-accumulate block.
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_e;

    // Result width: enough headroom for every psum/activation sign combination.
    function automatic int unsigned acc_width(input int unsigned psum_w,
                                              input int unsigned in_bits);
        return psum_w + in_bits;
    endfunction

    // Bit-plane counter width, $clog2(in_bits), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned in_bits);
        return (in_bits > 1) ? $clog2(in_bits) : 1;
    endfunction

endpackage

// File: rtl/shift_term.sv
// Extends one partial sum to the result width and weights it by its bit-plane position.
module shift_term
    import cim_pkg::*;
#(
    parameter int unsigned PSUM_W  = 6,
    parameter int unsigned IN_BITS = 8,
    parameter int unsigned ACC_W   = acc_width(PSUM_W, IN_BITS),
    parameter int unsigned CNT_W   = cnt_width(IN_BITS)
) (
    input  logic [PSUM_W-1:0] psum,
    input  logic              psum_signed,
    input  logic [CNT_W-1:0]  k,
    output logic [ACC_W-1:0]  term
);

    logic             ext_bit;
    logic [ACC_W-1:0] ext;

    // Sign- or zero-extend, then shift left by the plane index.
    always_comb begin
        ext_bit = psum_signed & psum[PSUM_W-1];
        ext     = {{(ACC_W - PSUM_W){ext_bit}}, psum};
        term    = ext << k;
    end

endmodule

// File: rtl/bitserial_shift_acc.sv
// Rebuilds a multi-bit dot product from per-bit-plane partial sums, LSB plane first.
module bitserial_shift_acc
    import cim_pkg::*;
#(
    parameter int unsigned PSUM_W  = 6,
    parameter int unsigned IN_BITS = 8,
    parameter int unsigned ACC_W   = acc_width(PSUM_W, IN_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] psum,
    input  logic              psum_signed,
    input  logic              act_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_signed
);

    localparam int unsigned CNT_W = cnt_width(IN_BITS);
    localparam logic [CNT_W-1:0] LastK = CNT_W'(IN_BITS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic             psum_signed_q;
    logic             act_signed_q;

    logic             beat;
    logic             first;
    logic             last;
    logic             eff_psum_signed;
    logic             eff_act_signed;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] acc_next;

    // Handshake, effective sign flags and the next accumulator value.
    always_comb begin
        in_ready        = (state_q == ACC);
        out_valid       = (state_q == DONE);
        beat            = in_valid & in_ready;
        first           = (cnt_q == '0);
        last            = (cnt_q == LastK);
        // Flags are taken live on plane 0 and frozen for the rest of the transaction.
        eff_psum_signed = first ? psum_signed : psum_signed_q;
        eff_act_signed  = first ? act_signed : act_signed_q;
        base            = first ? '0 : acc_q;
        // A signed activation's MSB plane carries negative weight.
        acc_next        = (last && eff_act_signed) ? (base - term) : (base + term);
        acc_out         = acc_q;
        out_signed      = psum_signed_q | act_signed_q;
    end

    shift_term #(
        .PSUM_W  (PSUM_W),
        .IN_BITS (IN_BITS),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W)
    ) u_shift_term (
        .psum        (psum),
        .psum_signed (eff_psum_signed),
        .k           (cnt_q),
        .term        (term)
    );

    // FSM, plane counter, accumulator and flag latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ACC;
            cnt_q         <= '0;
            acc_q         <= '0;
            psum_signed_q <= 1'b0;
            act_signed_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (beat) begin
                        acc_q <= acc_next;
                        if (first) begin
                            psum_signed_q <= psum_signed;
                            act_signed_q  <= act_signed;
                        end
                        if (last) begin
                            cnt_q   <= '0;
                            state_q <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_bitserial_shift_acc.sv
// Self-checking bench for bitserial_shift_acc (PSUM_W=6, IN_BITS=4, ACC_W=10).
module tb_bitserial_shift_acc;

    localparam int unsigned PSUM_W  = 6;
    localparam int unsigned IN_BITS = 4;
    localparam int unsigned ACC_W   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [PSUM_W-1:0] psum;
    logic              psum_signed;
    logic              act_signed;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              out_signed;

    int n_checks = 0;
    int n_errors = 0;
    int beats[IN_BITS];

    bitserial_shift_acc #(
        .PSUM_W  (PSUM_W),
        .IN_BITS (IN_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .psum        (psum),
        .psum_signed (psum_signed),
        .act_signed  (act_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .acc_out     (acc_out),
        .out_signed  (out_signed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dot-product value: sum of plane values times signed plane weights, modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] ref_result(input bit ps, input bit as);
        longint total = 0;
        for (int k = 0; k < IN_BITS; k++) begin
            longint v = beats[k];
            longint w = longint'(1) << k;
            if (ps && beats[k] >= (1 << (PSUM_W - 1))) v = v - (longint'(1) << PSUM_W);
            if (as && k == IN_BITS - 1) w = -w;
            total += v * w;
        end
        return ACC_W'(total);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it (bounded).
    task automatic send_beat(input int v, input bit ps, input bit as);
        bit taken = 1'b0;
        in_valid    = 1'b1;
        psum        = PSUM_W'(v);
        psum_signed = ps;
        act_signed  = as;
        for (int t = 0; t < 40 && !taken; t++) begin
            taken = in_ready;
            step();
        end
        if (!taken) begin
            n_checks++;
            n_errors++;
            $error("FAIL beat_timeout: observed no accept expected accept");
        end
        in_valid = 1'b0;
    endtask

    // Send beats[] as one transaction and check the result; optionally release it.
    task automatic run_txn(input string tag, input bit ps, input bit as, input int max_gap,
                           input bit toggle, input bit release_out);
        for (int k = 0; k < IN_BITS; k++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bit kps = (k == 0 || !toggle) ? ps : 1'($urandom);
            bit kas = (k == 0 || !toggle) ? as : 1'($urandom);
            for (int g = 0; g < gap; g++) begin
                psum = PSUM_W'($urandom);
                step();
            end
            if (k == IN_BITS - 1) check({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
            send_beat(beats[k], kps, kas);
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_acc"}, 32'(acc_out), 32'(ref_result(ps, as)));
        check({tag, "_signed"}, 32'(out_signed), 32'(ps | as));
        if (release_out) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check({tag, "_drop"}, 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        logic [ACC_W-1:0] held;
        rst         = 1'b1;
        in_valid    = 1'b0;
        psum        = '0;
        psum_signed = 1'b0;
        act_signed  = 1'b0;
        out_ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_out_signed", 32'(out_signed), 32'd0);

        beats = '{1, 2, 3, 4};
        run_txn("uns", 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("uns_49", 32'(ref_result(1'b0, 1'b0)), 32'd49);

        beats = '{5, 0, 0, 5};
        run_txn("act_neg", 1'b0, 1'b1, 0, 1'b0, 1'b1);

        beats = '{32, 32, 32, 32};
        run_txn("both_signed", 1'b1, 1'b1, 0, 1'b0, 1'b1);

        beats = '{63, 63, 63, 63};
        run_txn("max_gaps", 1'b0, 1'b0, 3, 1'b0, 1'b0);

        // Hold the result with a beat waiting upstream.
        held        = acc_out;
        in_valid    = 1'b1;
        psum        = PSUM_W'(7);
        psum_signed = 1'b0;
        act_signed  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_acc", 32'(acc_out), 32'(held));
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release", 32'(out_valid), 32'd0);
        beats = '{7, 0, 0, 0};
        // The held beat is still presented and is taken as plane 0.
        send_beat(7, 1'b0, 1'b0);
        for (int k = 1; k < IN_BITS; k++) send_beat(0, 1'b0, 1'b0);
        check("held_first_valid", 32'(out_valid), 32'd1);
        check("held_first_acc", 32'(acc_out), 32'd7);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Abort a transaction part-way with reset.
        send_beat(9, 1'b1, 1'b1);
        send_beat(9, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_acc", 32'(acc_out), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        beats = '{1, 1, 1, 1};
        send_beat(1, 1'b0, 1'b0);
        for (int k = 1; k < IN_BITS; k++) send_beat(1, 1'b1, 1'b0);
        check("midrst_acc15", 32'(acc_out), 32'd15);
        check("midrst_signed", 32'(out_signed), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Random transactions with flag toggling on later beats and random gaps.
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < IN_BITS; k++) beats[k] = int'($urandom_range(0, 63));
            run_txn("rand", 1'($urandom), 1'($urandom), 2, 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
